// File: rtl/id_buf.sv
// IF/ID pipeline buffer: captures fetched instruction + incremented PC, splits decode fields.
// Latency: 1 clock from inputs to every output; async active-low reset clears all outputs.
// Backpressure: none by default; with ID_BUF_STALL_EN defined, in_stall holds all registers (flush still wins).
module id_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in_instr,
  input  logic        in_haz,
  input  logic [5:0]  in_adder1,
`ifdef ID_BUF_STALL_EN
  input  logic        in_stall,
`endif
  output logic [15:0] out_haz,
  output logic [15:0] out_cntrl_logic,
  output logic        out_rst,
  output logic [5:0]  out_adder2,
  output logic [3:0]  out_op1_addr,
  output logic [3:0]  out_op2_addr,
  output logic [3:0]  out_imm_se2
);

  logic [15:0] r_instr;
  logic [5:0]  r_adder;
  logic        r_rst;
  logic        w_hold;

  // Hold only when stalled and no flush is requested; flush always takes priority.
`ifdef ID_BUF_STALL_EN
  assign w_hold = in_stall & ~in_haz;
`else
  assign w_hold = 1'b0;
`endif

  // Pipeline register: reset clears, flush inserts a bubble, otherwise capture unless held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= 16'd0;
      r_adder <= 6'd0;
      r_rst   <= 1'b0;
    end else if (in_haz) begin
      r_instr <= 16'd0;
      r_adder <= 6'd0;
      r_rst   <= 1'b1;
    end else if (!w_hold) begin
      r_instr <= in_instr;
      r_adder <= in_adder1;
      r_rst   <= 1'b0;
    end
  end

  // Decode fields are straight slices of the registered word; opcode travels via out_cntrl_logic.
  assign out_haz         = r_instr;
  assign out_cntrl_logic = r_instr;
  assign out_op1_addr    = r_instr[11:8];
  assign out_op2_addr    = r_instr[7:4];
  assign out_imm_se2     = r_instr[3:0];
  assign out_adder2      = r_adder;
  assign out_rst         = r_rst;

endmodule

// File: tb/tb_id_buf.sv
// Directed bench for id_buf with an expected-result queue.
// Expectations are pushed when a step is driven and popped one clock later.
// Stall steps are compiled in only when ID_BUF_STALL_EN is defined.
module tb_id_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_instr;
  logic        in_haz;
  logic [5:0]  in_adder1;
  logic        in_stall;
  logic [15:0] out_haz;
  logic [15:0] out_cntrl_logic;
  logic        out_rst;
  logic [5:0]  out_adder2;
  logic [3:0]  out_op1_addr;
  logic [3:0]  out_op2_addr;
  logic [3:0]  out_imm_se2;

  typedef struct {
    logic [15:0] word;
    logic [5:0]  adder;
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [3:0]  imm;
    logic        rst;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  id_buf dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_instr        (in_instr),
    .in_haz          (in_haz),
    .in_adder1       (in_adder1),
`ifdef ID_BUF_STALL_EN
    .in_stall        (in_stall),
`endif
    .out_haz         (out_haz),
    .out_cntrl_logic (out_cntrl_logic),
    .out_rst         (out_rst),
    .out_adder2      (out_adder2),
    .out_op1_addr    (out_op1_addr),
    .out_op2_addr    (out_op2_addr),
    .out_imm_se2     (out_imm_se2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [15:0] word, input logic [5:0] adder,
                      input logic [3:0] op1, input logic [3:0] op2,
                      input logic [3:0] imm, input logic rst);
    exp_t e;
    e.word = word; e.adder = adder; e.op1 = op1; e.op2 = op2; e.imm = imm; e.rst = rst;
    exp_q.push_back(e);
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, ".haz"},   out_haz,                 e.word);
    chk({tag, ".cntrl"}, out_cntrl_logic,         e.word);
    chk({tag, ".adder"}, {10'd0, out_adder2},     {10'd0, e.adder});
    chk({tag, ".op1"},   {12'd0, out_op1_addr},   {12'd0, e.op1});
    chk({tag, ".op2"},   {12'd0, out_op2_addr},   {12'd0, e.op2});
    chk({tag, ".imm"},   {12'd0, out_imm_se2},    {12'd0, e.imm});
    chk({tag, ".rst"},   {15'd0, out_rst},        {15'd0, e.rst});
  endtask

  // Drive on the falling edge, then compare one rising edge later against the queue head.
  task automatic step(input string tag, input logic [15:0] instr, input logic [5:0] adder,
                      input logic haz, input logic stall);
    exp_t e;
    @(negedge clk);
    in_instr = instr; in_adder1 = adder; in_haz = haz; in_stall = stall;
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp_all(tag, e);
    end
  endtask

  initial begin
    exp_t z;
    z.word = 16'd0; z.adder = 6'd0; z.op1 = 4'd0; z.op2 = 4'd0; z.imm = 4'd0; z.rst = 1'b0;

    // Reset with arbitrary inputs: outputs zero before any clock edge.
    rst_n = 1'b0; in_instr = 16'hFFFF; in_haz = 1'b1; in_adder1 = 6'h3F; in_stall = 1'b0;
    #3;
    cmp_all("reset_async", z);
    repeat (2) @(posedge clk);
    #1;
    cmp_all("reset_held", z);

    // Release and first capture.
    @(negedge clk);
    rst_n = 1'b1;
    push(16'b0000010101100100, 6'b000101, 4'b0101, 4'b0110, 4'b0100, 1'b0);
    step("first_cap", 16'b0000010101100100, 6'b000101, 1'b0, 1'b0);

    // Back-to-back capture.
    push(16'b0000000101010101, 6'b001011, 4'b0001, 4'b0101, 4'b0101, 1'b0);
    step("b2b_0", 16'b0000000101010101, 6'b001011, 1'b0, 1'b0);
    push(16'b0000000000000001, 6'b000100, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    step("b2b_1", 16'b0000000000000001, 6'b000100, 1'b0, 1'b0);

    // Field extraction, including opcode bits reaching control logic.
    push(16'h0448, 6'b001000, 4'b0100, 4'b0100, 4'b1000, 1'b0);
    step("fields", 16'b0000010001001000, 6'b001000, 1'b0, 1'b0);
    push(16'hA3C7, 6'b111110, 4'h3, 4'hC, 4'h7, 1'b0);
    step("opcode", 16'hA3C7, 6'b111110, 1'b0, 1'b0);

    // Flush, consecutive flush, then resume.
    push(16'd0, 6'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step("flush_0", 16'b0000010000101001, 6'b010101, 1'b1, 1'b0);
    push(16'd0, 6'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step("flush_1", 16'h1234, 6'b000011, 1'b1, 1'b0);
    push(16'b0000010000101001, 6'b010101, 4'b0100, 4'b0010, 4'b1001, 1'b0);
    step("resume", 16'b0000010000101001, 6'b010101, 1'b0, 1'b0);

`ifdef ID_BUF_STALL_EN
    // Stall holds every register while the input word changes.
    push(16'b0000010000101001, 6'b010101, 4'b0100, 4'b0010, 4'b1001, 1'b0);
    step("stall_0", 16'hBEEF, 6'b101010, 1'b0, 1'b1);
    push(16'b0000010000101001, 6'b010101, 4'b0100, 4'b0010, 4'b1001, 1'b0);
    step("stall_1", 16'h0F0F, 6'b010110, 1'b0, 1'b1);
    // Flush wins over stall, and a stalled bubble keeps out_rst high.
    push(16'd0, 6'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step("stall_flush", 16'h7777, 6'b000111, 1'b1, 1'b1);
    push(16'd0, 6'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step("stall_hold_rst", 16'h5555, 6'b001100, 1'b0, 1'b1);
    push(16'h5555, 6'b001100, 4'h5, 4'h5, 4'h5, 1'b0);
    step("unstall", 16'h5555, 6'b001100, 1'b0, 1'b0);
`endif

    // Load nonzero data, then start a flush and hit reset between edges.
    push(16'h0ABC, 6'b110011, 4'hA, 4'hB, 4'hC, 1'b0);
    step("pre_rst", 16'h0ABC, 6'b110011, 1'b0, 1'b0);
    push(16'd0, 6'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    step("flush_pre_rst", 16'h0ABC, 6'b110011, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    cmp_all("rst_mid_flush", z);
    @(posedge clk);
    #1;
    cmp_all("rst_mid_hold", z);

    // Release and confirm capture resumes.
    @(negedge clk);
    rst_n = 1'b1;
    push(16'h0321, 6'b000001, 4'h3, 4'h2, 4'h1, 1'b0);
    step("post_rst", 16'h0321, 6'b000001, 1'b0, 1'b0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
